// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch stage
// (read only) and the load/store stage. Each access is sequenced onto the
// backing bus through a req/ack handshake of variable latency. A response
// that never arrives is aborted after TIMEOUT bus cycles.
//
// The load/store stage has priority because it belongs to the older
// instruction. A starvation counter makes sure a waiting fetch gets the bus
// after STARVE_MAX consecutive load/store grants.
//
// Each access takes three phases: a grant cycle in IDLE, one or more bus
// cycles, and a single DONE cycle that pulses the requester's ready. No grant
// is made in DONE, so a request that is still high there is not served twice.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   if_req_i     fetch request (level, held until if_ready_o)
//   if_addr_i    fetch byte address
//   if_rdata_o   fetched instruction, valid with if_ready_o
//   if_ready_o   one-cycle fetch completion pulse
//   if_stall_o   if_req_i & ~if_ready_o
//   mem_rd_i     load request (level)
//   mem_wr_i     store request (level)
//   mem_addr_i   load/store byte address
//   mem_wdata_i  store data
//   mem_rdata_o  load data, valid with mem_ready_o
//   mem_ready_o  one-cycle load/store completion pulse
//   mem_stall_o  (mem_rd_i | mem_wr_i) & ~mem_ready_o
//   bus_req_o    registered backing-memory request
//   bus_we_o     1 = write cycle
//   bus_addr_o   registered bus address
//   bus_wdata_o  registered bus write data
//   bus_rdata_i  bus read data, sampled with bus_ack_i
//   bus_ack_i    single-cycle bus completion
//   bus_err_o    pulses together with ready when an access timed out
//   proto_err_o  sticky: load and store were requested together at a grant
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    output logic        if_stall_o,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic        proto_err_o
);

    localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS_IF,
        S_BUS_MEM,
        S_DONE
    } state_e;

    state_e        state_q;
    logic [SW-1:0] starve_cnt_q;
    logic [SW-1:0] starve_cnt_d;
    logic [7:0]    tmo_cnt_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   mem_rdata_q;
    logic          if_ready_q;
    logic          mem_ready_q;
    logic          bus_err_q;
    logic          proto_err_q;

    logic          mem_pend;
    logic          grant_mem;
    logic          grant_if;
    logic          bus_end;

    // Arbitration is evaluated only in IDLE; DONE never grants.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        mem_pend     = mem_rd_i | mem_wr_i;
        grant_mem    = 1'b0;
        grant_if     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        bus_end      = bus_ack_i || (tmo_cnt_q == TMO_LAST);

        if (state_q == S_IDLE) begin
            if (mem_pend && (!if_req_i || (starve_cnt_q < STARVE_SAT))) begin
                grant_mem = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end

        // Only MEM grants that overtake a waiting fetch count toward starvation.
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_mem && if_req_i && (starve_cnt_q < STARVE_SAT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the data and address registers are plain flops, so they are reset
        // too; the outputs must read zero while reset is asserted.
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // read below sees the value from before this clock edge.
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            starve_cnt_q <= starve_cnt_d;

            unique case (state_q)
                S_IDLE: begin
                    if (grant_mem) begin
                        state_q     <= S_BUS_MEM;
                        bus_req_q   <= 1'b1;
                        // A store wins when both strobes are high.
                        bus_we_q    <= mem_wr_i;
                        bus_addr_q  <= mem_addr_i;
                        bus_wdata_q <= mem_wdata_i;
                        tmo_cnt_q   <= '0;
                        if (mem_rd_i && mem_wr_i) begin
                            proto_err_q <= 1'b1;
                        end
                    end else if (grant_if) begin
                        state_q     <= S_BUS_IF;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= if_addr_i;
                        bus_wdata_q <= '0;
                        tmo_cnt_q   <= '0;
                    end
                end

                S_BUS_IF, S_BUS_MEM: begin
                    if (bus_end) begin
                        // An ack in the last allowed cycle still counts as success.
                        state_q   <= S_DONE;
                        bus_req_q <= 1'b0;
                        bus_err_q <= !bus_ack_i;
                        if (state_q == S_BUS_IF) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= bus_ack_i ? bus_rdata_i : 32'h0;
                        end else begin
                            mem_ready_q <= 1'b1;
                            if (!bus_ack_i) begin
                                mem_rdata_q <= 32'h0;
                            end else if (!bus_we_q) begin
                                mem_rdata_q <= bus_rdata_i;
                            end
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ready_o = mem_ready_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_err_o   = bus_err_q;
    assign proto_err_o = proto_err_q;

    // Stalls follow the request inputs directly so the pipeline freezes in the
    // same cycle a request appears.
    assign if_stall_o  = if_req_i & ~if_ready_q;
    assign mem_stall_o = (mem_rd_i | mem_wr_i) & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A transaction-level reference model
// follows the arbitration, starvation, timeout and data-capture rules and is
// compared with the DUT on every falling edge. The directed sequences also
// carry hand-computed literal expectations (cycle counts, grant order, data).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 255;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_ready_o (if_ready),
        .if_stall_o (if_stall),
        .mem_rd_i   (mem_rd),
        .mem_wr_i   (mem_wr),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata),
        .mem_ready_o(mem_ready),
        .mem_stall_o(mem_stall),
        .bus_req_o  (bus_req),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata),
        .bus_ack_i  (bus_ack),
        .bus_err_o  (bus_err),
        .proto_err_o(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Bus responder: acks on the (ack_delay+1)-th consecutive bus_req cycle;
    // ack_delay < 0 means never. extra_ack injects a stray ack.
    // ---------------------------------------------------------------------
    int          ack_delay = 0;
    logic [31:0] rd_val    = 32'h0;
    bit          extra_ack = 1'b0;
    int          bus_cnt   = 0;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (bus_req) begin
                bus_ack = ((ack_delay >= 0) && (bus_cnt == ack_delay)) || extra_ack;
                bus_cnt++;
            end else begin
                bus_cnt = 0;
                bus_ack = extra_ack;
            end
            bus_rdata = bus_ack ? rd_val : 32'hDEAD_BEEF;
        end
    end

    // ---------------------------------------------------------------------
    // Reference model: one owner of the bus at a time; each transaction is
    // granted, occupies the bus until ack or TIMEOUT bus cycles, then spends
    // one completion cycle signalling ready.
    // ---------------------------------------------------------------------
    typedef enum {OWN_NONE, OWN_IF, OWN_MEM} owner_e;

    owner_e      m_owner     = OWN_NONE;
    bit          m_finishing = 1'b0;
    bit          m_err       = 1'b0;
    bit          m_we        = 1'b0;
    bit          m_proto     = 1'b0;
    int          m_bus_cycles = 0;
    int          m_streak    = 0;
    logic [31:0] m_addr      = 32'h0;
    logic [31:0] m_wdata     = 32'h0;
    logic [31:0] m_if_rdata  = 32'h0;
    logic [31:0] m_mem_rdata = 32'h0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner      = OWN_NONE;
                m_finishing  = 1'b0;
                m_err        = 1'b0;
                m_we         = 1'b0;
                m_proto      = 1'b0;
                m_bus_cycles = 0;
                m_streak     = 0;
                m_addr       = 32'h0;
                m_wdata      = 32'h0;
                m_if_rdata   = 32'h0;
                m_mem_rdata  = 32'h0;
            end else if (m_finishing) begin
                m_finishing = 1'b0;
                m_err       = 1'b0;
                m_owner     = OWN_NONE;
            end else if (m_owner == OWN_NONE) begin
                if ((mem_rd || mem_wr) && (!if_req || m_streak < STARVE_MAX)) begin
                    m_owner      = OWN_MEM;
                    m_we         = mem_wr;
                    m_addr       = mem_addr;
                    m_wdata      = mem_wdata;
                    m_bus_cycles = 0;
                    if (if_req && m_streak < STARVE_MAX) m_streak++;
                    if (mem_rd && mem_wr) m_proto = 1'b1;
                end else if (if_req) begin
                    m_owner      = OWN_IF;
                    m_we         = 1'b0;
                    m_addr       = if_addr;
                    m_bus_cycles = 0;
                    m_streak     = 0;
                end
            end else begin
                m_bus_cycles++;
                if (bus_ack || m_bus_cycles == TIMEOUT) begin
                    m_finishing = 1'b1;
                    m_err       = !bus_ack;
                    if (m_owner == OWN_IF) begin
                        m_if_rdata = bus_ack ? bus_rdata : 32'h0;
                    end else if (!bus_ack) begin
                        m_mem_rdata = 32'h0;
                    end else if (!m_we) begin
                        m_mem_rdata = bus_rdata;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit on_bus;
                bit exp_ifr;
                bit exp_memr;
                on_bus   = (m_owner != OWN_NONE) && !m_finishing;
                exp_ifr  = m_finishing && (m_owner == OWN_IF);
                exp_memr = m_finishing && (m_owner == OWN_MEM);
                check("m_bus_req", bus_req, on_bus);
                check("m_if_ready", if_ready, exp_ifr);
                check("m_mem_ready", mem_ready, exp_memr);
                check("m_bus_err", bus_err, m_finishing && m_err);
                check("m_if_rdata", if_rdata, m_if_rdata);
                check("m_mem_rdata", mem_rdata, m_mem_rdata);
                check("m_proto_err", proto_err, m_proto);
                check("m_if_stall", if_stall, if_req && !exp_ifr);
                check("m_mem_stall", mem_stall, (mem_rd || mem_wr) && !exp_memr);
                if (on_bus) begin
                    check("m_bus_addr", bus_addr, m_addr);
                    check("m_bus_we", bus_we, m_we);
                    if (m_we) check("m_bus_wdata", bus_wdata, m_wdata);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Returns at the falling edge of the ready cycle; cycle index 0 is the
    // cycle the caller is in when it calls.
    task automatic wait_ready(input string name, input bit for_if, input int budget,
                              output int ncyc, output int nbus);
        ncyc = -1;
        nbus = 0;
        for (int i = 0; i < budget; i++) begin
            at_neg();
            if (bus_req) nbus++;
            if (for_if ? if_ready : mem_ready) begin
                ncyc = i;
                return;
            end
            step();
        end
        total++;
        bad++;
        $display("FAIL %s: no ready within %0d cycles", name, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Directed sequences
    // ---------------------------------------------------------------------
    initial begin
        int    ncyc;
        int    nbus;
        string seq;
        int    n_mem;
        int    n_if;

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;

        // Reset state
        repeat (2) at_neg();
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_if_ready", if_ready, 1'b0);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // 1: IF only, ack on first bus cycle
        ack_delay = 0;
        rd_val    = 32'h2008_0005;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        at_neg();
        check("t1_stall_c1", if_stall, 1'b1);
        check("t1_busreq_c1", bus_req, 1'b0);
        step();
        at_neg();
        check("t1_busreq_c2", bus_req, 1'b1);
        check("t1_addr", bus_addr, 32'h10);
        check("t1_we", bus_we, 1'b0);
        check("t1_stall_c2", if_stall, 1'b1);
        step();
        at_neg();
        check("t1_ready_c3", if_ready, 1'b1);
        check("t1_rdata", if_rdata, 32'h2008_0005);
        check("t1_stall_c3", if_stall, 1'b0);
        step();
        if_req = 1'b0;
        at_neg();
        check("t1_ready_c4", if_ready, 1'b0);
        step();

        // 2: simultaneous fetch and store; store first
        rd_val    = 32'h0BAD_C0DE;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0100;
        mem_wr    = 1'b1;
        mem_addr  = 32'h0000_0040;
        mem_wdata = 32'hCAFE_F00D;
        at_neg();
        check("t2_if_stall_c1", if_stall, 1'b1);
        check("t2_mem_stall_c1", mem_stall, 1'b1);
        step();
        at_neg();
        check("t2_we", bus_we, 1'b1);
        check("t2_addr", bus_addr, 32'h40);
        check("t2_wdata", bus_wdata, 32'hCAFE_F00D);
        check("t2_if_stall_c2", if_stall, 1'b1);
        step();
        at_neg();
        check("t2_mem_ready", mem_ready, 1'b1);
        check("t2_if_ready_c3", if_ready, 1'b0);
        check("t2_mem_rdata_kept", mem_rdata, 32'h0);
        check("t2_if_stall_c3", if_stall, 1'b1);
        step();
        mem_wr = 1'b0;
        at_neg();
        check("t2_idle_c4", bus_req, 1'b0);
        check("t2_if_stall_c4", if_stall, 1'b1);
        step();
        at_neg();
        check("t2_if_addr", bus_addr, 32'h100);
        check("t2_if_we", bus_we, 1'b0);
        step();
        at_neg();
        check("t2_if_ready", if_ready, 1'b1);
        check("t2_if_rdata", if_rdata, 32'h0BAD_C0DE);
        step();
        if_req = 1'b0;
        step();

        // 3: starvation guard
        seq      = "";
        n_mem    = 0;
        n_if     = 0;
        rd_val   = 32'h1111_0000;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        mem_rd   = 1'b1;
        mem_addr = 32'h0000_1000;
        for (int cyc = 0; cyc < 300 && n_mem < 10; cyc++) begin
            bit saw_m;
            bit saw_i;
            at_neg();
            saw_m = mem_ready;
            saw_i = if_ready;
            if (saw_m) begin
                seq = {seq, "M"};
                n_mem++;
            end
            if (saw_i) begin
                seq = {seq, "I"};
                n_if++;
            end
            step();
            if (saw_m) mem_addr = mem_addr + 32'd4;
            if (saw_i) if_addr = if_addr + 32'd4;
            rd_val = rd_val + 32'd1;
        end
        mem_rd = 1'b0;
        if_req = 1'b0;
        check("t3_mem_count", n_mem, 10);
        check("t3_if_count", n_if, 2);
        check_str("t3_order", seq.substr(0, 5), "MMMMIM");
        step();

        // 4: five wait states
        ack_delay = 5;
        rd_val    = 32'h1234_5678;
        mem_rd    = 1'b1;
        mem_addr  = 32'h0000_0080;
        wait_ready("t4_wait", 1'b0, 50, ncyc, nbus);
        check("t4_latency", ncyc, 7);
        check("t4_busreq_cycles", nbus, 6);
        check("t4_rdata", mem_rdata, 32'h1234_5678);
        step();
        mem_rd = 1'b0;
        step();

        // 5: timeout abort
        ack_delay = -1;
        mem_rd    = 1'b1;
        mem_addr  = 32'h0000_0300;
        wait_ready("t5_wait", 1'b0, 400, ncyc, nbus);
        check("t5_busreq_cycles", nbus, 255);
        check("t5_latency", ncyc, 256);
        check("t5_bus_err", bus_err, 1'b1);
        check("t5_rdata_zero", mem_rdata, 32'h0);
        step();
        mem_rd = 1'b0;
        at_neg();
        check("t5_err_cleared", bus_err, 1'b0);
        check("t5_ready_cleared", mem_ready, 1'b0);
        step();

        // 6: read and write together -> store, sticky protocol error
        ack_delay = 0;
        mem_rd    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = 32'h0000_0600;
        mem_wdata = 32'h0000_0055;
        at_neg();
        check("t6_proto_pre", proto_err, 1'b0);
        step();
        at_neg();
        check("t6_we", bus_we, 1'b1);
        check("t6_proto_set", proto_err, 1'b1);
        wait_ready("t6_wait", 1'b0, 10, ncyc, nbus);
        check("t6_rdata_kept", mem_rdata, 32'h0);
        step();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        at_neg();
        check("t6_proto_sticky", proto_err, 1'b1);
        step();

        // 7: reset in the second bus cycle
        ack_delay = -1;
        mem_rd    = 1'b1;
        mem_addr  = 32'h0000_0500;
        at_neg();
        step();
        at_neg();
        check("t7_bus_c1", bus_req, 1'b1);
        step();
        rst_n  = 1'b0;
        mem_rd = 1'b0;
        #1;
        check("t7_rst_bus_req", bus_req, 1'b0);
        check("t7_rst_bus_we", bus_we, 1'b0);
        check("t7_rst_bus_addr", bus_addr, 32'h0);
        check("t7_rst_mem_rdata", mem_rdata, 32'h0);
        check("t7_rst_if_rdata", if_rdata, 32'h0);
        check("t7_rst_proto", proto_err, 1'b0);
        check("t7_rst_stall", mem_stall, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        extra_ack = 1'b1;
        at_neg();
        check("t7_stray_ready_a", mem_ready | if_ready, 1'b0);
        step();
        extra_ack = 1'b0;
        at_neg();
        check("t7_stray_ready_b", mem_ready | if_ready, 1'b0);
        check("t7_stray_busreq", bus_req, 1'b0);
        step();
        ack_delay = 2;
        rd_val    = 32'h600D_0001;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0700;
        wait_ready("t7_wait", 1'b1, 20, ncyc, nbus);
        check("t7_if_latency", ncyc, 4);
        check("t7_if_rdata", if_rdata, 32'h600D_0001);
        step();
        if_req = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
